conv_window_addr_gen: RTL and testbench
=======================================

Name: conv_window_addr_gen

Overview:
- Sequencer that walks a 1-D convolution over an IFmap scratchpad.
- For each sliding window it emits one IFmap read address and one filter read address per cycle.
- After each window it waits for the downstream partial-sum accumulator to acknowledge.
- Sits directly upstream of the scratchpad read ports and the accumulator. It replaces hand-wired counter chains in the datapath controller and drives the same stall/clr discipline.

Parameters:
- ADDR_W, 5, width of IFmap address and IFmap length.
- FILT_W, 4, width of filter address, filter size and stride.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- ifmap_len  input  ADDR_W  N, number of valid IFmap words; latched on start.
- filt_size  input  FILT_W  F, filter length; latched on start.
- stride  input  FILT_W  S, window step; latched on start.
- stall  input  1  freezes all state when high.
- psum_ack  input  1  accumulator has consumed the current window.
- ifmap_addr  output  ADDR_W  base + k.
- filt_addr  output  FILT_W  k.
- addr_valid  output  1  addresses valid this cycle.
- window_last  output  1  current address pair is the last of its window.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at end of pass.
- err  output  1  parameter error; held until next accepted start.

Behaviour:
- States: IDLE, RUN, WAIT_ACK, FIN.
- Registers: base (ADDR_W), k (FILT_W), latched N/F/S, err.
- Reset: state=IDLE, base=0, k=0, err=0. All outputs 0 (ifmap_addr=0, filt_addr=0, addr_valid=0, window_last=0, busy=0, done=0).
- Reset mid-operation aborts immediately; no done pulse is issued.
- IDLE + start at edge t:
  - Latch N, F, S; base=0; k=0; err cleared.
  - If F==0, S==0 or F>N: err=1 and go to FIN.
  - Otherwise go to RUN. First addr_valid is in cycle t+1, so latency from start is 1 cycle.
- RUN:
  - addr_valid=1, ifmap_addr=base+k, filt_addr=k, window_last=(k==F-1).
  - If k<F-1: k++.
  - Else: k=0 and go to WAIT_ACK.
- WAIT_ACK:
  - addr_valid=0; wait for psum_ack.
  - On psum_ack: if base+S+F<=N (computed in ADDR_W+2 bits, no wrap), base+=S and go to RUN. Otherwise go to FIN.
  - psum_ack outside WAIT_ACK is ignored.
- FIN: done=1 for exactly one cycle, then IDLE.
- Stall:
  - When stall=1, no register changes in any state.
  - Outputs hold their current values, and addr_valid stays as it is.
  - A start or psum_ack arriving during stall is ignored and is not queued.
  - A pass stalled indefinitely must resume identically once stall drops.
- start while busy is ignored. Changes to N/F/S inputs after latching have no effect.
- Address outputs are combinational from registered state. No combinational path from inputs to outputs except through state.
- Window count = floor((N-F)/S)+1 when there is no error.
- Cycles per pass without stalls = windows*(F + ack wait + 1) + 2.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, RUN=2'd1, WAIT_ACK=2'd2, FIN=2'd3) and the default ADDR_W/FILT_W.
- One natural sub-module: conv_tap_counter. It is the inner k counter with max-count wrap, stall and clr, and a last-tap flag.
- Base stepping and the FSM stay in the top module.

Test Plan:
- N=8, F=3, S=2, psum_ack one cycle after each window_last:
  - Required ifmap_addr sequence is 0,1,2 | 2,3,4 | 4,5,6 (3 windows).
  - filt_addr sequence is 0,1,2 repeated.
  - window_last is high on the 3rd address of each window.
  - done pulses once; err=0.
- N=5, F=5, S=1: one window with ifmap_addr 0..4, then done. F=6, N=5: no addr_valid, err=1, done one cycle after start.
- S=0 or F=0 -> err=1 and done. A following legal start clears err.
- N=8, F=3, S=2 with stall held 3 cycles while k=1 of the 2nd window:
  - Outputs stay frozen at ifmap_addr=3.
  - The sequence resumes unchanged; no address is skipped or duplicated.
- psum_ack delayed 5 cycles: addr_valid=0 throughout the wait. A psum_ack pulse given during RUN is ignored.
- rst asserted mid-window (k=1): next cycle state is IDLE with all outputs 0 and no done pulse. A new start then runs the pass from base 0.

Source files
------------

// File: rtl/conv_window_addr_gen_pkg.sv
// rtl/conv_window_addr_gen_pkg.sv - shared state encoding and default widths for the conv window sequencer
package conv_window_addr_gen_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int FILT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_ACK = 2'd2,
      FIN      = 2'd3
   } state_t;
endpackage

// File: rtl/conv_window_addr_gen_if.sv
// rtl/conv_window_addr_gen_if.sv - pass control, scratchpad address and accumulator handshake bundle
interface conv_window_addr_gen_if
   import conv_window_addr_gen_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int FILT_W = FILT_W_DEF
);
   logic              start;
   logic [ADDR_W-1:0] ifmap_len;
   logic [FILT_W-1:0] filt_size;
   logic [FILT_W-1:0] stride;
   logic              stall;
   logic              psum_ack;
   logic [ADDR_W-1:0] ifmap_addr;
   logic [FILT_W-1:0] filt_addr;
   logic              addr_valid;
   logic              window_last;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, ifmap_len, filt_size, stride, stall, psum_ack,
      input  ifmap_addr, filt_addr, addr_valid, window_last, busy, done, err
   );

   modport slave (
      input  start, ifmap_len, filt_size, stride, stall, psum_ack,
      output ifmap_addr, filt_addr, addr_valid, window_last, busy, done, err
   );
endinterface

// File: rtl/conv_tap_counter.sv
// rtl/conv_tap_counter.sv - inner filter-tap counter with wrap at max_count, stall hold and clear
module conv_tap_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max_count,
   output logic [W-1:0] count,
   output logic         last
);
   assign last = (count == max_count);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (!stall) begin
         if (clr) begin
            count <= '0;
         end else if (en) begin
            count <= last ? '0 : count + W'(1);
         end
      end
   end
endmodule

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - 1-D convolution window walker emitting IFmap/filter read addresses
module conv_window_addr_gen
   import conv_window_addr_gen_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int FILT_W = FILT_W_DEF
) (
   input logic                  clk,
   input logic                  rst,
   conv_window_addr_gen_if.slave bus
);
   // Two extra bits so base+S+F never wraps before the compare against N.
   localparam int EXT_W = ADDR_W + 2;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] n_q;
   logic [FILT_W-1:0] f_q;
   logic [FILT_W-1:0] s_q;
   logic [FILT_W-1:0] k;
   logic              k_last;
   logic              err_q;
   logic              start_ok;
   logic              bad_cfg;
   logic              more_windows;

   assign start_ok     = (state == IDLE) && bus.start;
   assign bad_cfg      = (bus.filt_size == '0) || (bus.stride == '0) ||
                         (EXT_W'(bus.filt_size) > EXT_W'(bus.ifmap_len));
   assign more_windows = (EXT_W'(base) + EXT_W'(s_q) + EXT_W'(f_q)) <= EXT_W'(n_q);

   conv_tap_counter #(.W(FILT_W)) u_tap (
      .clk       (clk),
      .rst       (rst),
      .stall     (bus.stall),
      .clr       (start_ok),
      .en        (state == RUN),
      .max_count (f_q - FILT_W'(1)),
      .count     (k),
      .last      (k_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (!bus.stall) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.start) state_nxt = bad_cfg ? FIN : RUN;
         RUN:      if (k_last) state_nxt = WAIT_ACK;
         WAIT_ACK: if (bus.psum_ack) state_nxt = more_windows ? RUN : FIN;
         FIN:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base  <= '0;
         n_q   <= '0;
         f_q   <= '0;
         s_q   <= '0;
         err_q <= 1'b0;
      end else if (!bus.stall) begin
         if (start_ok) begin
            base  <= '0;
            n_q   <= bus.ifmap_len;
            f_q   <= bus.filt_size;
            s_q   <= bus.stride;
            err_q <= bad_cfg;
         end else if ((state == WAIT_ACK) && bus.psum_ack && more_windows) begin
            base <= base + ADDR_W'(s_q);
         end
      end
   end

   always_comb begin
      bus.addr_valid  = (state == RUN);
      bus.window_last = (state == RUN) && k_last;
      bus.busy        = (state != IDLE);
      bus.done        = (state == FIN);
   end

   assign bus.ifmap_addr = base + ADDR_W'(k);
   assign bus.filt_addr  = k;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// tb/tb_conv_window_addr_gen.sv - scoreboard bench for conv_window_addr_gen
module tb_conv_window_addr_gen;
   import conv_window_addr_gen_pkg::*;

   localparam int AW = 5;
   localparam int FW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_window_addr_gen_if #(.ADDR_W(AW), .FILT_W(FW)) bus ();
   conv_window_addr_gen #(.ADDR_W(AW), .FILT_W(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit is_done;
      int ifa;
      int fa;
      bit last;
      bit err;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   bit   rand_stall = 0;
   bit   force_stall = 0;
   bit   spurious = 0;
   bit   junk = 0;
   int   fixed_delay = 0;
   int   wcnt = 0;
   int   cur_delay = 0;

   function automatic void check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endfunction

   function automatic bit is_bad(int n, int f, int s);
      return (f == 0) || (s == 0) || (f > n);
   endfunction

   // Reference: every window b = 0, S, 2S, ... while b+F <= N reads taps 0..F-1.
   task automatic push_pass(input int n, input int f, input int s);
      exp_t e;
      if (is_bad(n, f, s)) begin
         e = '{1'b1, 0, 0, 1'b0, 1'b1};
         sbq.push_back(e);
      end else begin
         for (int b = 0; b + f <= n; b += s)
            for (int t = 0; t < f; t++) begin
               e = '{1'b0, b + t, t, (t == f - 1), 1'b0};
               sbq.push_back(e);
            end
         e = '{1'b1, 0, 0, 1'b0, 1'b0};
         sbq.push_back(e);
      end
   endtask

   function automatic int exp_busy(int n, int f, int s, int d);
      if (is_bad(n, f, s)) return 1;
      return ((n - f) / s + 1) * (f + d + 1) + 1;
   endfunction

   // Monitor: an output is consumed on an edge where stall is low.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sbq.delete();
      end else if (!bus.stall) begin
         if (bus.addr_valid) begin
            if (sbq.size() == 0 || sbq[0].is_done) begin
               check("unexpected_addr", int'(bus.ifmap_addr), -1);
            end else begin
               e = sbq.pop_front();
               check("ifmap_addr", int'(bus.ifmap_addr), e.ifa);
               check("filt_addr", int'(bus.filt_addr), e.fa);
               check("window_last", int'(bus.window_last), int'(e.last));
            end
         end
         if (bus.done) begin
            if (sbq.size() == 0 || !sbq[0].is_done) begin
               check("unexpected_done", int'(bus.done), 0);
            end else begin
               e = sbq.pop_front();
               check("done_err", int'(bus.err), int'(e.err));
            end
         end
      end
   end

   // Stall and accumulator-ack driver.
   always @(posedge clk) begin
      #1;
      bus.stall = force_stall || (rand_stall && ($urandom % 5 == 0));
      if (rst) begin
         bus.psum_ack = 1'b0;
         wcnt = 0;
      end else if (bus.busy && !bus.addr_valid && !bus.done) begin
         bus.psum_ack = (wcnt >= cur_delay);
         wcnt++;
      end else begin
         wcnt = 0;
         cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom % 6);
         bus.psum_ack = spurious && bus.addr_valid && !bus.window_last && ($urandom % 3 == 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
      if (junk && bus.busy) begin
         bus.start     = ($urandom % 3 == 0);
         bus.ifmap_len = AW'($urandom);
         bus.filt_size = FW'($urandom);
         bus.stride    = FW'($urandom);
      end else begin
         bus.start = 1'b0;
      end
   endtask

   // probe: 0 none, 1 hold stall 3 cycles at k=1 of window 2, 2 reset at k=1 of window 1
   task automatic run_pass(input int n, input int f, input int s, input int exp_cycles, input int probe);
      int guard;
      int cyc;
      int sc;
      bit bad;
      bad   = is_bad(n, f, s);
      guard = 0;
      sc    = 0;
      step();
      while ((bus.busy || bus.stall) && guard < 500) begin
         step();
         guard++;
      end
      if (guard >= 500) begin
         check("idle_timeout", guard, 0);
         return;
      end
      bus.ifmap_len = AW'(n);
      bus.filt_size = FW'(f);
      bus.stride    = FW'(s);
      bus.start     = 1'b1;
      push_pass(n, f, s);
      step();
      if (bad) begin
         check("err_done_latency", int'(bus.done), 1);
         check("err_flag", int'(bus.err), 1);
         check("err_no_valid", int'(bus.addr_valid), 0);
      end else begin
         check("first_valid", int'(bus.addr_valid), 1);
         check("first_ifmap", int'(bus.ifmap_addr), 0);
         check("err_cleared", int'(bus.err), 0);
      end
      cyc   = 0;
      guard = 0;
      while (bus.busy && guard < 3000) begin
         cyc++;
         guard++;
         if (probe == 1) begin
            if (sc == 0 && bus.addr_valid && bus.filt_addr == 0 && bus.ifmap_addr == 2) begin
               force_stall = 1'b1;
               sc = 1;
            end else if (sc >= 1 && sc <= 3) begin
               check("stall_hold_addr", int'(bus.ifmap_addr), 3);
               check("stall_hold_valid", int'(bus.addr_valid), 1);
               sc++;
               if (sc == 4) force_stall = 1'b0;
            end
         end
         if (probe == 2 && bus.addr_valid && bus.filt_addr == 1) begin
            rst = 1'b1;
            step();
            check("rst_busy", int'(bus.busy), 0);
            check("rst_valid", int'(bus.addr_valid), 0);
            check("rst_ifmap", int'(bus.ifmap_addr), 0);
            check("rst_filt", int'(bus.filt_addr), 0);
            check("rst_last", int'(bus.window_last), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_err", int'(bus.err), 0);
            rst = 1'b0;
            return;
         end
         step();
      end
      if (guard >= 3000) check("pass_timeout", guard, 0);
      if (exp_cycles >= 0) check("busy_cycles", cyc, exp_cycles);
      check("queue_drained", sbq.size(), 0);
      check("err_held", int'(bus.err), int'(bad));
   endtask

   initial begin
      int n, f, s;
      bus.start     = 1'b0;
      bus.ifmap_len = '0;
      bus.filt_size = '0;
      bus.stride    = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", int'(bus.busy), 0);
      check("reset_valid", int'(bus.addr_valid), 0);
      check("reset_ifmap", int'(bus.ifmap_addr), 0);
      check("reset_filt", int'(bus.filt_addr), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_err", int'(bus.err), 0);
      rst = 1'b0;

      run_pass(8, 3, 2, 13, 0);
      run_pass(5, 5, 1, 7, 0);
      run_pass(5, 6, 1, 1, 0);
      run_pass(8, 3, 0, 1, 0);
      run_pass(8, 0, 2, 1, 0);
      run_pass(6, 2, 3, 7, 0);

      fixed_delay = 5;
      spurious    = 1;
      run_pass(8, 3, 2, 28, 0);
      fixed_delay = 0;
      spurious    = 0;
      run_pass(8, 3, 2, 16, 1);
      run_pass(8, 3, 2, -1, 2);
      run_pass(8, 3, 2, 13, 0);

      fixed_delay = -1;
      rand_stall  = 1;
      spurious    = 1;
      junk        = 1;
      for (int i = 0; i < 40; i++) begin
         n = int'($urandom % 32);
         f = (i % 4 == 0) ? int'($urandom % 16) : int'($urandom % 9);
         s = int'($urandom % 6);
         run_pass(n, f, s, -1, 0);
      end

      fixed_delay = 2;
      rand_stall  = 0;
      for (int i = 0; i < 10; i++) begin
         n = int'($urandom % 32);
         f = int'($urandom % 9);
         s = int'($urandom % 6);
         run_pass(n, f, s, exp_busy(n, f, s, 2), 0);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
